// File: rtl/syncer_arb_pkg.sv
// Shared definitions for the syncer_bus arbiter/sequencer.
package syncer_arb_pkg;

  // IDLE waits for a request; HOLD keeps the granted word steady on bus_out.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester with req high,
// starting the search one past the previous grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] w_idx;

  // The search runs from the farthest candidate to the nearest, so the
  // nearest requester after last_grant is the one that ends up selected.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/syncer_bus_arb.sv
// Round-robin arbiter and update sequencer in front of a shared syncer_bus.
// A granted word is held on bus_out for HOLD_CYCLES cycles, and then done is
// pulsed back to its requester.
//
//   state   | meaning
//   --------+----------------------------------------------
//   ST_IDLE | no transfer in progress, waiting for any req
//   ST_HOLD | granted word held on bus_out, cnt counting down
module syncer_bus_arb
  import syncer_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic [WIDTH-1:0]           bus_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_bus, w_bus_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;
  logic [IDX_W-1:0] r_gid, w_gid_nxt;
  logic [IDX_W-1:0] r_last, w_last_nxt;

  logic             w_gnt_valid;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [WIDTH-1:0] w_sel_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (r_last),
    .gnt_valid  (w_gnt_valid),
    .gnt_idx    (w_gnt_idx)
  );

  // Pick the word of the requester the arbiter is selecting this cycle.
  always_comb begin
    w_sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == w_gnt_idx) w_sel_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state and next-output logic; req is only looked at while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bus_nxt   = r_bus;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_busy_nxt  = r_busy;
    w_gid_nxt   = r_gid;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_bus_nxt   = w_sel_word;
          w_gid_nxt   = w_gnt_idx;
          w_last_nxt  = w_gnt_idx;
          w_ack_nxt   = NUM_REQ'(1) << w_gnt_idx;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_done_nxt  = NUM_REQ'(1) << r_gid;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; last grant resets to the top index so
  // requester 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bus   <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_gid   <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bus   <= w_bus_nxt;
      r_ack   <= w_ack_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_gid   <= w_gid_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign ack      = r_ack;
  assign done     = r_done;
  assign bus_out  = r_bus;
  assign grant_id = r_gid;
  assign busy     = r_busy;

endmodule
